// File: rtl/saradc_seq_pkg.sv
// saradc_seq_pkg: shared state encoding and default sizes for the SAR sequencer
package saradc_seq_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SMP = 2'd1, CONV = 2'd2, DONE = 2'd3} state_t;
  localparam int NBITS_DEF = 8;
  localparam int SMPW_DEF  = 4;
endpackage

// File: rtl/saradc_seq.sv
// saradc_seq: SAR conversion sequencer with sampling window, continuous mode and fault flag
module saradc_seq
  import saradc_seq_pkg::*;
#(
  parameter int NBITS = NBITS_DEF,
  parameter int SMPW  = SMPW_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_cont,
  input  logic [SMPW-1:0]  i_smpcyc,
  input  logic             i_cmpp,
  input  logic             i_cmpn,
  output logic             o_sample,
  output logic             o_valid,
  output logic [NBITS-1:1] o_resultp,
  output logic [NBITS-1:1] o_resultn,
  output logic [NBITS-1:0] o_dout,
  output logic             o_done,
  output logic             o_busy,
  output logic             o_err
);
  localparam int KW = (NBITS > 2) ? $clog2(NBITS) : 1;
  state_t           r_state, w_next;
  logic [SMPW-1:0]  r_scnt;
  logic [KW-1:0]    r_k;
  logic [NBITS-1:0] r_shadow, w_sh;
  logic             w_bit, w_fault, w_go, w_enter;
  // a faulted decision (both rails equal) resolves to 0
  assign w_bit   = i_cmpp & ~i_cmpn;
  assign w_fault = i_cmpp == i_cmpn;
  assign w_go    = i_start | i_cont;
  assign w_enter = (r_state == IDLE || r_state == DONE) && w_next == SMP;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_go ? SMP : IDLE;
      SMP:     w_next = (r_scnt == '0) ? CONV : SMP;
      CONV:    w_next = (r_k == '0) ? DONE : CONV;
      default: w_next = w_go ? SMP : IDLE;
    endcase
  end
  always_comb begin
    w_sh = r_shadow;
    w_sh[r_k] = w_bit;
  end
  // outputs are registered from the next state so they align with the state they describe
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_scnt    <= '0;
      r_k       <= '0;
      r_shadow  <= '0;
      o_sample  <= 1'b0;
      o_valid   <= 1'b0;
      o_resultp <= '0;
      o_resultn <= '0;
      o_dout    <= '0;
      o_done    <= 1'b0;
      o_busy    <= 1'b0;
      o_err     <= 1'b0;
    end else begin
      o_sample <= w_next == SMP;
      o_busy   <= w_next == SMP || w_next == CONV;
      o_done   <= w_next == DONE;
      o_valid  <= (w_next == DONE) ? 1'b1 : (w_next == SMP) ? 1'b0 : o_valid;
      if (w_enter) begin
        r_scnt    <= i_smpcyc;
        r_k       <= KW'(NBITS - 1);
        o_resultp <= '0;
        o_resultn <= '0;
        o_err     <= 1'b0;
      end else if (r_state == SMP) r_scnt <= r_scnt - 1'b1;
      if (r_state == CONV) begin
        r_shadow <= w_sh;
        r_k      <= r_k - 1'b1;
        if (w_fault) o_err <= 1'b1;
        if (r_k != '0) begin
          o_resultp[r_k] <= w_bit;
          o_resultn[r_k] <= ~w_bit;
        end else o_dout <= w_sh;
      end
    end
endmodule

// File: tb/tb_saradc_seq.sv
// tb_saradc_seq: directed checks of sampling window, conversion timing, CONT mode, faults and reset
module tb_saradc_seq;
  logic       clk = 0, rst_n = 0, start = 0, cont = 0;
  logic [3:0] smpcyc = 4'd2;
  logic       cmpp, cmpn;
  logic       o_sample, o_valid, o_done, o_busy, o_err;
  logic [7:1] o_resultp, o_resultn;
  logic [7:0] o_dout;
  int         ecnt = 0, t0 = 1000000, m_smp = 2, fbit = -1, n_chk = 0, n_pass = 0;
  logic [7:0] codes [2];

  saradc_seq #(.NBITS(8), .SMPW(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_cont(cont), .i_smpcyc(smpcyc),
    .i_cmpp(cmpp), .i_cmpn(cmpn), .o_sample(o_sample), .o_valid(o_valid),
    .o_resultp(o_resultp), .o_resultn(o_resultn), .o_dout(o_dout), .o_done(o_done),
    .o_busy(o_busy), .o_err(o_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ecnt <= ecnt + 1;

  // comparator model: bit captured at edge t0+smp+2+j is code[7-j], repeating every smp+10 edges
  always_comb begin : cmp_model
    int rel, per, j, k, ci;
    logic [7:0] c;
    rel = ecnt + 1 - t0;
    per = m_smp + 10;
    cmpp = 1'b0;
    cmpn = 1'b1;
    if (rel >= 0) begin
      j  = rel % per - m_smp - 2;
      ci = (rel / per) % 2;
      c  = codes[ci];
      if (j >= 0 && j < 8) begin
        k = 7 - j;
        if (k == fbit) {cmpp, cmpn} = 2'b11;
        else {cmpp, cmpn} = {c[k], ~c[k]};
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic start_conv(input logic [7:0] c0, input logic [7:0] c1, input int smp,
                            input int fb, input logic cm);
    @(negedge clk);
    codes[0] = c0;
    codes[1] = c1;
    m_smp    = smp;
    fbit     = fb;
    smpcyc   = 4'(smp);
    cont     = cm;
    start    = 1'b1;
    t0       = ecnt + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    codes[0] = 8'h00;
    codes[1] = 8'h00;
    #7;
    chk("rst_outs", {25'd0, o_sample, o_valid, o_done, o_busy, o_err}, 0);
    chk("rst_res", {18'd0, o_resultp, o_resultn}, 0);
    chk("rst_dout", o_dout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", o_busy, 0);

    start_conv(8'hA5, 8'hA5, 2, -1, 1'b0);
    for (int r = 0; r <= 13; r++) begin
      chk("A_sample", o_sample, r <= 2);
      chk("A_done", o_done, r == 11);
      chk("A_busy", o_busy, r <= 10);
      if (r == 3) chk("A_res3", {o_resultp, o_resultn}, 0);
      if (r == 4) chk("A_res4", {o_resultp, o_resultn}, {7'h40, 7'h00});
      if (r == 5) chk("A_res5", {o_resultp, o_resultn}, {7'h40, 7'h20});
      if (r == 11) begin
        chk("A_valid", o_valid, 1);
        chk("A_dout", o_dout, 8'hA5);
        chk("A_resp", o_resultp, 7'h52);
        chk("A_resn", o_resultn, 7'h2D);
        chk("A_err", o_err, 0);
      end
      if (r == 13) chk("A_valid_idle", o_valid, 1);
      @(negedge clk);
    end

    start_conv(8'h00, 8'hFF, 2, -1, 1'b1);
    for (int r = 0; r <= 26; r++) begin
      if (r == 14) cont = 1'b0;
      chk("C_sample", o_sample, r < 24 && r % 12 <= 2);
      chk("C_done", o_done, r == 11 || r == 23);
      chk("C_valid", o_valid, r == 11 || r >= 23);
      chk("C_overlap", o_valid & o_sample, 0);
      if (r == 11) chk("C_dout0", o_dout, 8'h00);
      if (r == 23) chk("C_dout1", o_dout, 8'hFF);
      if (r >= 24) chk("C_idle", o_busy, 0);
      @(negedge clk);
    end

    start_conv(8'hFF, 8'hFF, 2, 5, 1'b0);
    for (int r = 0; r <= 12; r++) begin
      if (r == 5) chk("F_err5", o_err, 0);
      if (r == 6) chk("F_err6", o_err, 1);
      if (r == 11) begin
        chk("F_dout", o_dout, 8'hDF);
        chk("F_resn", o_resultn, 7'h10);
        chk("F_resp", o_resultp, 7'h6F);
      end
      if (r == 12) chk("F_err_idle", o_err, 1);
      @(negedge clk);
    end
    start_conv(8'hFF, 8'hFF, 2, -1, 1'b0);
    chk("F_err_clr", o_err, 0);
    for (int r = 0; r <= 12; r++) begin
      if (r == 11) chk("F2_dout", o_dout, 8'hFF);
      @(negedge clk);
    end

    start_conv(8'h3C, 8'h3C, 2, -1, 1'b0);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("R_flags", {27'd0, o_sample, o_valid, o_done, o_busy, o_err}, 0);
    chk("R_res", {18'd0, o_resultp, o_resultn}, 0);
    chk("R_dout", o_dout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      chk("R_idle", {o_sample, o_busy, o_done, o_valid}, 0);
      chk("R_idle_dout", o_dout, 0);
    end

    start_conv(8'hC3, 8'hC3, 2, -1, 1'b0);
    for (int r = 0; r <= 13; r++) begin
      start = (r == 5);
      chk("S_sample", o_sample, r <= 2);
      chk("S_done", o_done, r == 11);
      if (r == 11) chk("S_dout", o_dout, 8'hC3);
      @(negedge clk);
    end
    start = 1'b0;

    start_conv(8'h5A, 8'h5A, 0, -1, 1'b0);
    for (int r = 0; r <= 11; r++) begin
      chk("Z_sample", o_sample, r == 0);
      chk("Z_done", o_done, r == 9);
      if (r == 9) chk("Z_dout", o_dout, 8'h5A);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
